led_pwm: RTL
============

Name: led_pwm

Overview:
- Memory-mapped PWM peripheral that sits directly downstream of the data-memory store path and drives the board's RGB and user LED pins.
- The CPU writes duty, control and prescale registers with ordinary stores; the block generates four 8-bit PWM channels.
- Duty values are double-buffered so that a duty change never produces a glitched period.
- Pin outputs are active-low; the block does the inversion itself.

Parameters:
- BASE_ADDR, 32'h0000_1000: byte address of register 0. The block decodes addresses BASE_ADDR..BASE_ADDR+0xF.
- PRESCALE_RESET, 16'd46: reset value of the PRESCALE register. At 12 MHz this gives about a 1 kHz PWM frame.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset. It is sampled only on the rising edge of clk.
- wr_en, input, 1: store strobe, asserted for one cycle per store.
- wr_be, input, 4: byte enables for wdata (sb = 1 bit set, sh = 2, sw = 4).
- addr, input, 32: byte address of the access, used for both read and write.
- wdata, input, 32: store data.
- rdata, output, 32: registered read data, valid 1 cycle after addr is presented.
- hit, output, 1: combinational; high when addr is within the block's window.
- red_n, output, 1: active-low PWM pin, channel R.
- green_n, output, 1: active-low PWM pin, channel G.
- blue_n, output, 1: active-low PWM pin, channel B.
- led_n, output, 1: active-low PWM pin, channel LED.

Behaviour:
- Register map (word offsets from BASE_ADDR):
  - 0x0 CTRL: bit0 EN, bit1 INV; other bits read 0.
  - 0x4 DUTY_PEND: [7:0] R, [15:8] G, [23:16] B, [31:24] LED.
  - 0x8 PRESCALE: [15:0]; bits [31:16] read 0.
  - 0xC STATUS, read-only: [7:0] frame counter cnt, [15:8] active R duty, [31:16] frame_count (wraps).
- Writes:
  - Take effect on the clk edge where wr_en && hit.
  - Only bytes with wr_be set are updated.
  - Writes to STATUS are ignored.
  - Writes outside the window are ignored.
- Reset values:
  - CTRL = 0, DUTY_PEND = 0, DUTY_ACT = 0, PRESCALE = PRESCALE_RESET.
  - Prescale counter pc = 0, cnt = 0, frame_count = 0, rdata = 0.
  - All pin outputs = 1 (LEDs off).
- Prescaler:
  - When EN = 1: tick = (pc == PRESCALE). On tick, pc <= 0; otherwise pc <= pc + 1.
  - PRESCALE = 0 gives a tick every cycle.
  - If PRESCALE is written below the current pc, pc wraps naturally at 16 bits; no special handling is required.
- Frame counter:
  - cnt is 8-bit and advances by 1 on each tick.
  - cnt 255 -> 0 is end-of-frame (eof).
  - On eof: DUTY_ACT <= DUTY_PEND and frame_count <= frame_count + 1.
- Disabled (EN = 0):
  - pc and cnt are held at 0.
  - DUTY_ACT <= DUTY_PEND every cycle (immediate update).
  - Every channel's raw output is 0.
- Channel raw output: on_x = EN && (cnt < DUTY_ACT_x), registered. Duty 0 is always off; duty 255 is on for 255/256 of the frame.
- Pin output:
  - x_n = ~(on_x ^ INV), registered.
  - Pin latency from cnt change is 1 cycle.
  - When INV = 1 and EN = 0, the pins read 0 (lit).
- Reads: rdata <= the register selected by addr[3:2] on every clk edge. Read data is unaffected by wr_en in the same cycle, i.e. old data is returned.
- Simultaneous write to DUTY_PEND and eof in the same cycle: DUTY_ACT takes the old DUTY_PEND; the new value is applied at the next eof.
- Clearing EN mid-frame: pins go inactive 1 cycle after the write edge; cnt = 0.
- Setting EN: counting starts from cnt = 0 and pc = 0.
- Reset asserted mid-frame: all state returns to reset values on that edge, regardless of wr_en.

Test Plan:
- Reset check: assert reset 2 cycles with wr_en = 1 -> all _n = 1, rdata = 0, PRESCALE reads 46, STATUS reads 0.
- Basic PWM: PRESCALE = 0, DUTY = 0x00FF_4000, EN = 1 -> per 256-cycle frame:
  - green_n low for exactly 64 cycles.
  - blue_n low for 255 cycles.
  - red_n and led_n always high.
  - frame_count increments every 256 cycles.
- Double buffering: mid-frame, write DUTY R = 0x10 while R = 0x80 is active -> current frame keeps 128 low cycles; next frame has 16.
- Write/eof collision: store DUTY on the exact eof cycle -> next frame still shows the old duty; the following frame shows the new one.
- Byte write and prescale: sb of 0x20 to offset 0x5, PRESCALE = 3 ->
  - only G changes to 0x20.
  - tick every 4 cycles; green low for 128 of 1024 cycles.
- INV and disable: EN = 1, INV = 1, DUTY all 0x00 -> all pins low. Then write CTRL = 0 -> pins high the next cycle, STATUS cnt = 0, DUTY_ACT follows DUTY_PEND immediately.

Source files
------------

// File: rtl/led_pwm_if.sv
`default_nettype none
// ============================================================================
//  Module   : led_pwm_if
//  Purpose  : Store/read bus between the data-memory path and led_pwm.
//             The master drives the access, the slave returns read data
//             and the window-hit flag.
//  Revision : 1.0  initial release
// ============================================================================
interface led_pwm_if;
  logic        wr_en;
  logic [3:0]  wr_be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        hit;

  modport master (output wr_en, wr_be, addr, wdata, input rdata, hit);
  modport slave  (input wr_en, wr_be, addr, wdata, output rdata, hit);
endinterface
`default_nettype wire

// File: rtl/led_pwm.sv
`default_nettype none
// ============================================================================
//  Module   : led_pwm
//  Purpose  : Memory-mapped 4-channel 8-bit PWM driving active-low LED pins.
//             Duty values are double-buffered and swapped at end of frame.
//  Revision : 1.0  initial release
// ============================================================================
module led_pwm #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_1000,
  parameter logic [15:0] PRESCALE_RESET = 16'd46
) (
  input  wire logic  clk,
  input  wire logic  reset,
  led_pwm_if.slave   bus,
  output logic       red_n,
  output logic       green_n,
  output logic       blue_n,
  output logic       led_n
);

  localparam logic [1:0] REG_CTRL     = 2'd0;
  localparam logic [1:0] REG_DUTY     = 2'd1;
  localparam logic [1:0] REG_PRESCALE = 2'd2;
  localparam logic [1:0] REG_STATUS   = 2'd3;

  logic [1:0]  ctrl;
  logic [31:0] duty_pend;
  logic [31:0] duty_act;
  logic [15:0] prescale;
  logic [15:0] pc;
  logic [7:0]  cnt;
  logic [15:0] frame_count;
  logic [31:0] rdata_q;
  logic [3:0]  pins;

  logic        en;
  logic        inv;
  logic        wr;
  logic [1:0]  sel;
  logic        tick;
  logic        eof;
  logic [3:0]  on;
  logic [31:0] duty_merged;
  logic [31:0] status;
  logic        unused_bits;

  // Byte-lane merge for partial stores (sb/sh).
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    return r;
  endfunction

  // The window is 16 bytes aligned on BASE_ADDR, so only the upper bits decide a hit.
  assign bus.hit     = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign wr          = bus.wr_en && bus.hit;
  assign sel         = bus.addr[3:2];
  assign en          = ctrl[0];
  assign inv         = ctrl[1];
  assign tick        = en && (pc == prescale);
  assign eof         = tick && (cnt == 8'hFF);
  assign duty_merged = merge_bytes(duty_pend, bus.wdata, bus.wr_be);
  assign status      = {frame_count, duty_act[7:0], cnt};
  assign unused_bits = ^bus.addr[1:0];

  // Channel comparators; bit order {R, G, B, LED}.
  assign on = {4{en}} & {(cnt < duty_act[7:0]),
                         (cnt < duty_act[15:8]),
                         (cnt < duty_act[23:16]),
                         (cnt < duty_act[31:24])};

  // CPU-writable registers; STATUS and out-of-window stores fall through.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl      <= 2'b00;
      duty_pend <= 32'h0;
      prescale  <= PRESCALE_RESET;
    end else if (wr) begin
      case (sel)
        REG_CTRL: begin
          if (bus.wr_be[0]) ctrl <= bus.wdata[1:0];
        end
        REG_DUTY: duty_pend <= duty_merged;
        REG_PRESCALE: begin
          if (bus.wr_be[0]) prescale[7:0]  <= bus.wdata[7:0];
          if (bus.wr_be[1]) prescale[15:8] <= bus.wdata[15:8];
        end
        default: ;
      endcase
    end
  end

  // Prescaler, frame counter and duty double-buffer; disabled means held at zero
  // with the active duty tracking the pending one.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= 16'h0;
      cnt         <= 8'h0;
      frame_count <= 16'h0;
      duty_act    <= 32'h0;
    end else if (!en) begin
      pc       <= 16'h0;
      cnt      <= 8'h0;
      duty_act <= duty_pend;
    end else if (tick) begin
      pc  <= 16'h0;
      cnt <= cnt + 8'd1;
      if (eof) begin
        duty_act    <= duty_pend;
        frame_count <= frame_count + 16'd1;
      end
    end else begin
      pc <= pc + 16'd1;
    end
  end

  // Registered active-low pins with optional polarity inversion.
  always_ff @(posedge clk) begin
    if (reset) pins <= 4'hF;
    else       pins <= ~(on ^ {4{inv}});
  end

  // Read mux sampled every cycle; a same-cycle store is not visible yet.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= 32'h0;
    end else begin
      case (sel)
        REG_CTRL:     rdata_q <= {30'h0, ctrl};
        REG_DUTY:     rdata_q <= duty_pend;
        REG_PRESCALE: rdata_q <= {16'h0, prescale};
        REG_STATUS:   rdata_q <= status;
        default:      rdata_q <= 32'h0;
      endcase
    end
  end

  assign bus.rdata = rdata_q;
  assign red_n     = pins[3];
  assign green_n   = pins[2];
  assign blue_n    = pins[1];
  assign led_n     = pins[0];

endmodule
`default_nettype wire
